// File: rtl/sa_pkg.sv
// Shared types and sizing helpers for the SA_CORE tile sequencer.
package sa_pkg;

  // Array geometry defaults shared with SA_CORE.
  localparam int unsigned SA_ROWS = 8;
  localparam int unsigned SA_COLS = 8;
  localparam int unsigned SA_KMAX = 255;

  typedef enum logic [2:0] {
    IDLE,
    LOADW,
    STREAM,
    DRAIN,
    DONE
  } sa_seq_state_t;

  // Index width that never collapses to zero bits for a size-1 dimension.
  function automatic int unsigned idx_w(int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sa_seq_ctrl_if.sv
// Control/handshake bundle between the tile sequencer and its neighbours.
interface sa_seq_ctrl_if
  import sa_pkg::*;
#(
  parameter int unsigned ROWS = SA_ROWS,
  parameter int unsigned COLS = SA_COLS,
  parameter int unsigned KMAX = SA_KMAX
) ();

  localparam int unsigned KW  = $clog2(KMAX + 1);
  localparam int unsigned RW  = idx_w(ROWS);
  localparam int unsigned CLW = idx_w(COLS);

  logic            start;
  logic            abort;
  logic [KW-1:0]   k_len;
  logic            out_ready;
  logic            busy;
  logic            w_load;
  logic [RW-1:0]   w_row;
  logic            fire;
  logic [ROWS-1:0] a_lane_en;
  logic            drain;
  logic [CLW-1:0]  drain_col;
  logic            done;

  // Sequencer side.
  modport master (
    input  start, abort, k_len, out_ready,
    output busy, w_load, w_row, fire, a_lane_en, drain, drain_col, done
  );

  // Config regs / PE_ARR / col capture side.
  modport slave (
    output start, abort, k_len, out_ready,
    input  busy, w_load, w_row, fire, a_lane_en, drain, drain_col, done
  );

endinterface

// File: rtl/sa_skew_gen.sv
// Diagonal activation skew: lane r is live for stream steps r .. r+k_len-1.
module sa_skew_gen #(
  parameter int unsigned ROWS = 8,
  parameter int unsigned KW   = 8,
  parameter int unsigned CW   = 12
) (
  input  logic [CW-1:0]   t,
  input  logic [KW-1:0]   k_len,
  output logic [ROWS-1:0] lane_en
);

  // Per-lane window compare; CW is wide enough that r+k_len never wraps.
  always_comb begin
    lane_en = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      lane_en[r] = (t >= CW'(r)) && (t < (CW'(r) + CW'(k_len)));
    end
  end

endmodule

// File: rtl/sa_seq_ctrl.sv
// Tile sequencer for PE_ARR: weight load, skewed activation stream, column drain, done.
module sa_seq_ctrl
  import sa_pkg::*;
#(
  parameter int unsigned ROWS = SA_ROWS,
  parameter int unsigned COLS = SA_COLS,
  parameter int unsigned KMAX = SA_KMAX
) (
  input logic           clk,
  input logic           rstn,
  sa_seq_ctrl_if.master bus
);

  localparam int unsigned KW  = $clog2(KMAX + 1);
  localparam int unsigned RW  = idx_w(ROWS);
  localparam int unsigned CLW = idx_w(COLS);
  // Shared counter must hold the longest stream length k_len+ROWS+COLS-2.
  localparam int unsigned CW  = KW + $clog2(ROWS + COLS) + 1;

  localparam logic [CW-1:0] FillFlush = CW'(ROWS + COLS - 2);
  localparam logic [CW-1:0] RowLast   = CW'(ROWS - 1);
  localparam logic [CW-1:0] ColLast   = CW'(COLS - 1);

  sa_seq_state_t   state;
  logic [CW-1:0]   cnt;
  logic [KW-1:0]   k_q;
  logic            busy_q;
  logic            w_load_q;
  logic [RW-1:0]   w_row_q;
  logic            fire_q;
  logic [ROWS-1:0] lane_q;
  logic            drain_q;
  logic [CLW-1:0]  drain_col_q;
  logic            done_q;

  logic [CW-1:0]   cnt_inc;
  logic [CW-1:0]   t_last;
  logic [CW-1:0]   t_next;
  logic [ROWS-1:0] lane_nxt;

  // Counter arithmetic and the stream step the lane mask is computed for.
  always_comb begin
    cnt_inc = cnt + CW'(1);
    // k_q >= 1 whenever STREAM is reached, so this never underflows.
    t_last  = CW'(k_q) + FillFlush - CW'(1);
    t_next  = (state == LOADW) ? '0 : cnt_inc;
  end

  sa_skew_gen #(
    .ROWS (ROWS),
    .KW   (KW),
    .CW   (CW)
  ) u_skew (
    .t       (t_next),
    .k_len   (k_q),
    .lane_en (lane_nxt)
  );

  // Sequencer FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      cnt         <= '0;
      k_q         <= '0;
      busy_q      <= 1'b0;
      w_load_q    <= 1'b0;
      w_row_q     <= '0;
      fire_q      <= 1'b0;
      lane_q      <= '0;
      drain_q     <= 1'b0;
      drain_col_q <= '0;
      done_q      <= 1'b0;
    end else begin
      w_load_q <= 1'b0;
      fire_q   <= 1'b0;
      lane_q   <= '0;
      drain_q  <= 1'b0;
      done_q   <= 1'b0;
      if (bus.abort) begin
        state       <= IDLE;
        cnt         <= '0;
        busy_q      <= 1'b0;
        w_row_q     <= '0;
        drain_col_q <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              k_q    <= bus.k_len;
              busy_q <= 1'b1;
              cnt    <= '0;
              if (bus.k_len == '0) begin
                state  <= DONE;
                done_q <= 1'b1;
              end else begin
                state    <= LOADW;
                w_load_q <= 1'b1;
                w_row_q  <= '0;
              end
            end
          end
          LOADW: begin
            if (cnt == RowLast) begin
              state   <= STREAM;
              cnt     <= '0;
              w_row_q <= '0;
              fire_q  <= 1'b1;
              lane_q  <= lane_nxt;
            end else begin
              cnt      <= cnt_inc;
              w_load_q <= 1'b1;
              w_row_q  <= RW'(cnt_inc);
            end
          end
          STREAM: begin
            if (cnt == t_last) begin
              state       <= DRAIN;
              cnt         <= '0;
              drain_q     <= 1'b1;
              drain_col_q <= '0;
            end else begin
              cnt    <= cnt_inc;
              fire_q <= 1'b1;
              lane_q <= lane_nxt;
            end
          end
          DRAIN: begin
            drain_q <= 1'b1;
            if (bus.out_ready) begin
              if (cnt == ColLast) begin
                state       <= DONE;
                cnt         <= '0;
                drain_q     <= 1'b0;
                drain_col_q <= '0;
                done_q      <= 1'b1;
              end else begin
                cnt         <= cnt_inc;
                drain_col_q <= CLW'(cnt_inc);
              end
            end
          end
          DONE: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
          default: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.w_load    = w_load_q;
  assign bus.w_row     = w_row_q;
  assign bus.fire      = fire_q;
  assign bus.a_lane_en = lane_q;
  assign bus.drain     = drain_q;
  assign bus.drain_col = drain_col_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_sa_seq_ctrl.sv
// Directed bench for sa_seq_ctrl with a 4x4 array.
module tb_sa_seq_ctrl;

  typedef struct packed {
    logic       busy;
    logic       w_load;
    logic [1:0] w_row;
    logic       fire;
    logic [3:0] lane;
    logic       drain;
    logic [1:0] col;
    logic       done;
  } outs_t;

  typedef struct {
    logic       start;
    logic [7:0] k_len;
    outs_t      exp;
  } vec_t;

  logic clk;
  logic rstn;
  int   n_cmp;
  int   n_fail;

  localparam int NVEC = 19;
  vec_t       tbl[NVEC];
  logic [3:0] lanes[9];

  sa_seq_ctrl_if #(.ROWS(4), .COLS(4), .KMAX(255)) bus ();

  sa_seq_ctrl #(.ROWS(4), .COLS(4), .KMAX(255)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic outs_t o(logic b, logic wl, logic [1:0] wr, logic f, logic [3:0] ln,
                              logic d, logic [1:0] c, logic dn);
    outs_t r;
    r = '{busy: b, w_load: wl, w_row: wr, fire: f, lane: ln, drain: d, col: c, done: dn};
    return r;
  endfunction

  function automatic vec_t mk(logic s, logic [7:0] k, outs_t e);
    vec_t v;
    v.start = s;
    v.k_len = k;
    v.exp   = e;
    return v;
  endfunction

  function automatic outs_t sample();
    return o(bus.busy, bus.w_load, bus.w_row, bus.fire, bus.a_lane_en, bus.drain,
             bus.drain_col, bus.done);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, outs_t exp);
    outs_t got;
    got = sample();
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got busy=%b wl=%b row=%0d fire=%b lane=%h drain=%b col=%0d done=%b, want busy=%b wl=%b row=%0d fire=%b lane=%h drain=%b col=%0d done=%b",
               name, got.busy, got.w_load, got.w_row, got.fire, got.lane, got.drain,
               got.col, got.done, exp.busy, exp.w_load, exp.w_row, exp.fire, exp.lane,
               exp.drain, exp.col, exp.done);
    end
  endtask

  task automatic check_int(string name, int got, int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, got, exp);
    end
  endtask

  // Apply the reference k_len=3 tile; each row gives inputs before an edge and outputs after.
  task automatic run_table(string tag);
    bus.out_ready = 1'b1;
    bus.abort     = 1'b0;
    for (int i = 0; i < NVEC; i++) begin
      bus.start = tbl[i].start;
      bus.k_len = tbl[i].k_len;
      tick();
      check($sformatf("%s[%0d]", tag, i), tbl[i].exp);
    end
  endtask

  outs_t zero;

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    zero   = '0;

    lanes[0] = 4'h1; lanes[1] = 4'h3; lanes[2] = 4'h7; lanes[3] = 4'hE; lanes[4] = 4'hC;
    lanes[5] = 4'h8; lanes[6] = 4'h0; lanes[7] = 4'h0; lanes[8] = 4'h0;
    tbl[0] = mk(1'b1, 8'd3, o(1, 1, 2'd0, 0, 4'h0, 0, 2'd0, 0));
    for (int i = 1; i < 4; i++) tbl[i] = mk(1'b0, 8'd3, o(1, 1, 2'(i), 0, 4'h0, 0, 2'd0, 0));
    for (int t = 0; t < 9; t++) tbl[4 + t] = mk(1'b0, 8'd3, o(1, 0, 2'd0, 1, lanes[t], 0, 2'd0, 0));
    for (int c = 0; c < 4; c++) tbl[13 + c] = mk(1'b0, 8'd3, o(1, 0, 2'd0, 0, 4'h0, 1, 2'(c), 0));
    tbl[17] = mk(1'b0, 8'd3, o(1, 0, 2'd0, 0, 4'h0, 0, 2'd0, 1));
    tbl[18] = mk(1'b0, 8'd3, zero);

    // Reset
    rstn = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.k_len = 8'd0; bus.out_ready = 1'b0;
    tick();
    tick();
    check("reset", zero);
    rstn = 1'b1;
    tick();
    check("idle_after_reset", zero);

    // 1: basic tile
    run_table("tile");

    // 2: backpressure on column 2
    bus.start = 1'b1; bus.k_len = 8'd3; bus.out_ready = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 13; i++) tick();
    check("bp_col0", o(1, 0, 2'd0, 0, 4'h0, 1, 2'd0, 0));
    tick();
    check("bp_col1", o(1, 0, 2'd0, 0, 4'h0, 1, 2'd1, 0));
    tick();
    check("bp_col2", o(1, 0, 2'd0, 0, 4'h0, 1, 2'd2, 0));
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("bp_hold%0d", i), o(1, 0, 2'd0, 0, 4'h0, 1, 2'd2, 0));
    end
    bus.out_ready = 1'b1;
    tick();
    check("bp_col3", o(1, 0, 2'd0, 0, 4'h0, 1, 2'd3, 0));
    tick();
    check("bp_done", o(1, 0, 2'd0, 0, 4'h0, 0, 2'd0, 1));
    tick();
    check("bp_idle", zero);

    // 3: empty tile
    bus.start = 1'b1; bus.k_len = 8'd0;
    tick();
    bus.start = 1'b0;
    check("k0_done", o(1, 0, 2'd0, 0, 4'h0, 0, 2'd0, 1));
    tick();
    check("k0_idle", zero);

    // abort wins over start in IDLE
    bus.start = 1'b1; bus.abort = 1'b1; bus.k_len = 8'd3;
    tick();
    check("abort_beats_start", zero);
    bus.start = 1'b0; bus.abort = 1'b0;
    tick();
    check("abort_beats_start_idle", zero);

    // 4: abort at stream step 4
    bus.start = 1'b1; bus.k_len = 8'd3;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("abort_at_t4", o(1, 0, 2'd0, 1, 4'hC, 0, 2'd0, 0));
    bus.abort = 1'b1;
    tick();
    check("abort_idle", zero);
    bus.abort = 1'b0;
    tick();
    check("abort_no_done", zero);
    run_table("post_abort");

    // 5: async reset during drain
    bus.start = 1'b1; bus.k_len = 8'd3;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    check("pre_reset_col1", o(1, 0, 2'd0, 0, 4'h0, 1, 2'd1, 0));
    #2 rstn = 1'b0;
    #1;
    check("async_reset", zero);
    tick();
    check("held_reset", zero);
    rstn = 1'b1;
    run_table("post_reset");

    // 6: long tile, start held, k_len changed after capture
    begin
      int n_fire;
      int n_wl;
      bit got_done;
      n_fire   = 0;
      n_wl     = 0;
      got_done = 1'b0;
      bus.start = 1'b1; bus.k_len = 8'd255;
      tick();
      bus.k_len = 8'd5;
      for (int c = 0; c < 400 && !got_done; c++) begin
        if (bus.fire === 1'b1) n_fire++;
        if (bus.w_load === 1'b1) n_wl++;
        if (bus.done === 1'b1) got_done = 1'b1;
        else tick();
      end
      check_int("long_done_seen", int'(got_done), 1);
      check_int("long_fire_cycles", n_fire, 261);
      check_int("long_wload_cycles", n_wl, 4);
      tick();
      check("long_idle_after_done", zero);
      tick();
      check("long_restart", o(1, 1, 2'd0, 0, 4'h0, 0, 2'd0, 0));
      bus.start = 1'b0; bus.abort = 1'b1;
      tick();
      check("long_abort", zero);
      bus.abort = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
